// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Purpose : shared definitions for the data-memory responder slice.
//           Holds the funct3 access-size codes, the responder FSM encoding and
//           a helper that tells whether a size code names a real access.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // 011, 110 and 111 have no meaning as a load/store width.
  function automatic logic size_legal(logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) ||
           (sz == SZ_BU) || (sz == SZ_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purpose : purely combinational lane steering between a 32-bit RAM word and a
//           right-aligned byte/half/word access.
// Ports   :
//   size        in  3   funct3 access size
//   addr_lo     in  2   byte offset within the word
//   range_err   in  1   word address lies beyond the RAM
//   wdata       in  32  right-aligned store data
//   rword       in  32  RAM word read at the access address
//   byte_en     out 4   per-lane write enable (all zero on error)
//   wdata_lanes out 32  store data replicated into its lane positions
//   rdata_ext   out 32  aligned and sign/zero-extended load result (0 on error)
//   err         out 1   illegal size, misaligned or out of range
// -----------------------------------------------------------------------------
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        range_err,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic        misaligned;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    misaligned = 1'b0;
    if ((size == SZ_H || size == SZ_HU) && addr_lo[0])
      misaligned = 1'b1;
    if (size == SZ_W && addr_lo != 2'b00)
      misaligned = 1'b1;
    err = !size_legal(size) || misaligned || range_err;
  end

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata_ext = 32'd0;
    case (size)
      SZ_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
      SZ_BU:   rdata_ext = {24'd0, rbyte};
      SZ_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
      SZ_HU:   rdata_ext = {16'd0, rhalf};
      SZ_W:    rdata_ext = rword;
      default: rdata_ext = 32'd0;
    endcase
    if (err)
      rdata_ext = 32'd0;
  end

  // Data is replicated across every lane so only byte_en decides what lands.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    case (size)
      SZ_B, SZ_BU: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      SZ_W: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
      end
    endcase
    if (err)
      byte_en = 4'b0000;
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Purpose : responder for the core's data-memory port. Accepts one load/store
//           at a time over valid/ready, waits LATENCY cycles, then performs the
//           RAM access and presents a registered response until taken.
// Parameters:
//   DEPTH    number of 32-bit words (power of 2, >= 4)
//   LATENCY  cycles from the accepting edge to rsp_valid high (1..15)
// Ports   :
//   clk, rst   clock, synchronous active-high reset
//   req_valid  in  1   request present
//   req_ready  out 1   responder idle and able to accept
//   req_we     in  1   1 = store, 0 = load
//   req_addr   in  32  byte address
//   req_wdata  in  32  right-aligned store data
//   req_size   in  3   funct3 size code
//   rsp_valid  out 1   response present
//   rsp_ready  in  1   requester takes response
//   rsp_rdata  out 32  load result (0 for stores and errors)
//   rsp_err    out 1   access rejected
// -----------------------------------------------------------------------------
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         DIRECT    = (LATENCY == 1);
  // BUSY lasts LATENCY-1 cycles; the counter counts down to zero inside it.
  localparam logic [3:0] BUSY_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;

  logic [31:0] mem [0:DEPTH-1];

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_size;
  logic [AW-1:0] word_idx;
  logic        range_err;
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;
  logic        err;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (DIRECT && state == IDLE && accept) ||
                      (state == BUSY && cnt == 4'd0);

  // With LATENCY=1 the access happens on the accept edge itself, so the live
  // request is used; otherwise the latched copy is.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_size  = req_size;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
    end
  end

  assign word_idx  = cur_addr[AW+1:2];
  assign range_err = (cur_addr[31:AW+2] != '0);
  assign rword     = mem[word_idx];

  mem_lane_align u_align (
    .size        (cur_size),
    .addr_lo     (cur_addr[1:0]),
    .range_err   (range_err),
    .wdata       (cur_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .err         (err)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
    end
  end

  // Writes only on the edge entering RESP; a reset before then drops the store.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[word_idx][i*8 +: 8] <= wdata_lanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            cnt       <= BUSY_INIT;
            state     <= DIRECT ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
        end
        RESP: begin
          // Ready is raised here so an accept is only possible one cycle later.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= cur_we ? 32'd0 : rdata_ext;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Three responders share clock, reset and request fields; sel picks which one
// sees req_valid. Instance 0 uses LATENCY=2, instance 1 LATENCY=4 and
// instance 2 LATENCY=1. The driver pushes each expected response into a
// queue; a negedge monitor pops and compares whenever a responder presents one.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int NDUT  = 3;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_ready;
  int          sel;

  logic [NDUT-1:0] rv_vec;
  logic [NDUT-1:0] req_ready_v;
  logic [NDUT-1:0] rsp_valid_v;
  logic [NDUT-1:0] rsp_err_v;
  logic [31:0]     rsp_rdata_v [NDUT];

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  logic prev_valid [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign rv_vec[g] = req_valid && (sel == g);
    data_mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 4 : 1))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (rv_vec[g]),
      .req_ready (req_ready_v[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .rsp_valid (rsp_valid_v[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata_v[g]),
      .rsp_err   (rsp_err_v[g])
    );
  end

  function automatic int lat_of(int d);
    case (d)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] size,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic expect_rsp, input string name);
    bit got = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready_v[sel] === 1'b1)
        got = 1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s accept: got no req_ready expected req_ready within 100 cycles", name);
    end else begin
      last_acc = cyc + 1;
      if (expect_rsp)
        sb.push_back('{dut: sel, rdata: exp_rdata, err: exp_err, acc: last_acc, name: name});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) prev_valid[d] = 1'b0;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (rsp_valid_v[d] === 1'b1) begin
          if (sb.size() == 0 || sb[0].dut != d) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected response: got rsp_valid=1 on dut %0d expected none", d);
          end else begin
            if (!prev_valid[d])
              checkOutput({sb[0].name, " latency"}, 32'(cyc - sb[0].acc + 1), 32'(lat_of(d)));
            checkOutput({sb[0].name, " rdata"}, rsp_rdata_v[d], sb[0].rdata);
            checkOutput({sb[0].name, " err"}, 32'(rsp_err_v[d]), 32'(sb[0].err));
            if (rsp_ready === 1'b1)
              void'(sb.pop_front());
          end
        end
        prev_valid[d] = rsp_valid_v[d];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_acc;
    logic [31:0] b2b_data [4];
    b2b_data[0] = 32'h01234567;
    b2b_data[1] = 32'h89ABCDEF;
    b2b_data[2] = 32'hFFFF0000;
    b2b_data[3] = 32'h0000FFFF;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = SZ_W; rsp_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("reset req_ready", 32'(req_ready_v[d]), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid_v[d]), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata_v[d], 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err_v[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++)
      checkOutput("ready after reset", 32'(req_ready_v[d]), 32'd1);

    // LATENCY=2 responder: data path vectors
    sel = 0;
    applyStimulus(1, 32'h10,  32'hDEADBEEF, SZ_W,  32'h0,        0, 1, "sw_10");
    applyStimulus(0, 32'h10,  32'h0,        SZ_W,  32'hDEADBEEF, 0, 1, "lw_10");
    applyStimulus(1, 32'h20,  32'h0,        SZ_W,  32'h0,        0, 1, "sw_20");
    applyStimulus(1, 32'h21,  32'h80,       SZ_B,  32'h0,        0, 1, "sb_21");
    applyStimulus(0, 32'h21,  32'h0,        SZ_B,  32'hFFFFFF80, 0, 1, "lb_21");
    applyStimulus(0, 32'h21,  32'h0,        SZ_BU, 32'h00000080, 0, 1, "lbu_21");
    applyStimulus(0, 32'h20,  32'h0,        SZ_W,  32'h00008000, 0, 1, "lw_20");
    applyStimulus(1, 32'h13,  32'h1234,     SZ_H,  32'h0,        1, 1, "sh_13_mis");
    applyStimulus(0, 32'h10,  32'h0,        SZ_W,  32'hDEADBEEF, 0, 1, "lw_10_kept");
    applyStimulus(0, 32'h400, 32'h0,        SZ_W,  32'h0,        1, 1, "lw_oor");
    applyStimulus(0, 32'h10,  32'h0,        3'b011, 32'h0,       1, 1, "ld_size011");
    applyStimulus(0, 32'h12,  32'h0,        SZ_H,  32'hFFFFDEAD, 0, 1, "lh_12");
    applyStimulus(0, 32'h12,  32'h0,        SZ_HU, 32'h0000DEAD, 0, 1, "lhu_12");
    applyStimulus(0, 32'h13,  32'h0,        SZ_B,  32'hFFFFFFDE, 0, 1, "lb_13");
    applyStimulus(0, 32'h12,  32'h0,        SZ_W,  32'h0,        1, 1, "lw_12_mis");
    applyStimulus(1, 32'h22,  32'hCAFE,     SZ_H,  32'h0,        0, 1, "sh_22");
    applyStimulus(0, 32'h20,  32'h0,        SZ_W,  32'hCAFE8000, 0, 1, "lw_20_half");
    applyStimulus(0, 32'h20,  32'h0,        SZ_HU, 32'h00008000, 0, 1, "lhu_20");
    applyStimulus(1, 32'h10,  32'h55555555, 3'b111, 32'h0,       1, 1, "st_size111");
    applyStimulus(0, 32'h10,  32'h0,        SZ_W,  32'hDEADBEEF, 0, 1, "lw_10_kept2");
    applyStimulus(1, 32'h0,   32'h0,        SZ_W,  32'h0,        0, 1, "sw_00");
    applyStimulus(1, 32'h400, 32'h12345678, SZ_W,  32'h0,        1, 1, "sw_oor");
    applyStimulus(0, 32'h0,   32'h0,        SZ_W,  32'h0,        0, 1, "lw_00_kept");
    waitIdle();

    // Response held off by the requester
    rsp_ready = 1'b0;
    applyStimulus(0, 32'h10, 32'h0, SZ_W, 32'hDEADBEEF, 0, 1, "lw_hold");
    for (int i = 0; i < 20 && rsp_valid_v[0] !== 1'b1; i++)
      @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("hold rsp_valid", 32'(rsp_valid_v[0]), 32'd1);
      checkOutput("hold rsp_rdata", rsp_rdata_v[0], 32'hDEADBEEF);
      checkOutput("hold req_ready", 32'(req_ready_v[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("ready after handshake", 32'(req_ready_v[0]), 32'd1);
    checkOutput("valid after handshake", 32'(rsp_valid_v[0]), 32'd0);
    waitIdle();

    // LATENCY=4 responder: reset while a store is in BUSY
    sel = 1;
    applyStimulus(1, 32'h40, 32'h11111111, SZ_W, 32'h0, 0, 1, "sw_40_old");
    waitIdle();
    applyStimulus(1, 32'h40, 32'h22222222, SZ_W, 32'h0, 0, 0, "sw_40_dropped");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no rsp after reset", 32'(rsp_valid_v[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 32'h40, 32'h0, SZ_W, 32'h11111111, 0, 1, "lw_40_old");
    waitIdle();

    // LATENCY=1 responder: alternating store/load at full rate
    sel = 2;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        applyStimulus(1, 32'h80, b2b_data[i/2], SZ_W, 32'h0, 0, 1, $sformatf("b2b_sw%0d", i));
      else
        applyStimulus(0, 32'h80, 32'h0, SZ_W, b2b_data[i/2], 0, 1, $sformatf("b2b_lw%0d", i));
      if (i > 0)
        checkOutput($sformatf("b2b spacing %0d", i), 32'(last_acc - prev_acc), 32'd2);
      prev_acc = last_acc;
    end
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
